// File: rtl/systolic_ofmap_deskew.sv
// systolic_ofmap_deskew: realigns the diagonally skewed bottom-row partial sums of a
// systolic array into whole rows and buffers them in a small FIFO drained over valid/ready.
module systolic_ofmap_deskew #(
    parameter int unsigned OFMAP_WIDTH = 32,
    parameter int unsigned ARRAY_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      enable,
    input  logic                                      ofmap_valid_in,
    input  logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0]   ofmap_in,
    output logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0]   ofmap_out,
    output logic                                      ofmap_valid,
    input  logic                                      ofmap_ready,
    output logic                                      full,
    output logic [$clog2(FIFO_DEPTH):0]               count,
    output logic                                      overflow,
    input  logic                                      clear_overflow
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] row_t;

    row_t                    aligned_row;
    logic [ARRAY_WIDTH-2:0]  vld_q;
    row_t                    mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]         wptr_q, rptr_q;
    logic [CntW-1:0]         count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    push, pop, accept, drop;

    // Column j is delayed by ARRAY_WIDTH-1-j enabled cycles; the last column passes live.
    for (genvar j = 0; j < ARRAY_WIDTH - 1; j++) begin : g_skew
        localparam int unsigned Depth = ARRAY_WIDTH - 1 - j;
        logic [OFMAP_WIDTH-1:0] pipe_q [Depth];

        // Enable-gated shift of this column's skew registers (data needs no reset).
        always_ff @(posedge clk) begin
            if (enable) begin
                pipe_q[0] <= ofmap_in[j];
                for (int k = 1; k < int'(Depth); k++) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end

        assign aligned_row[j] = pipe_q[Depth-1];
    end
    assign aligned_row[ARRAY_WIDTH-1] = ofmap_in[ARRAY_WIDTH-1];

    // Row-valid marker travels alongside column 0 through the skew window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (enable) begin
            vld_q[0] <= ofmap_valid_in;
            for (int k = 1; k < int'(ARRAY_WIDTH) - 1; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign ofmap_valid = (count_q != '0);
    assign full        = (count_q == CntW'(FIFO_DEPTH));
    assign count       = count_q;
    assign overflow    = overflow_q;
    // Gate the head so the output reads zero whenever nothing is buffered.
    assign ofmap_out   = ofmap_valid ? mem_q[rptr_q] : '0;

    // Push/pop decode and next-state for count and the sticky overflow flag.
    always_comb begin
        push       = enable & vld_q[ARRAY_WIDTH-2];
        pop        = ofmap_valid & ofmap_ready;
        // A full FIFO still accepts when the head leaves on the same edge.
        accept     = push & (~full | pop);
        drop       = push & full & ~pop;
        count_d    = count_q;
        overflow_d = overflow_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO pointers, occupancy and overflow state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) wptr_q <= wptr_q + PtrW'(1);
            if (pop)    rptr_q <= rptr_q + PtrW'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Row storage; contents are only observable through the gated head.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem_q[wptr_q] <= aligned_row;
        end
    end

endmodule

// File: tb/tb_systolic_ofmap_deskew.sv
// tb_systolic_ofmap_deskew: directed test-plan scenarios plus randomized traffic, all
// checked against a queue-based row/FIFO model.
module tb_systolic_ofmap_deskew;

    localparam int W  = 32;
    localparam int AW = 4;
    localparam int FD = 4;
    localparam int RowW = AW * W;

    typedef logic [AW-1:0][W-1:0] row_t;

    logic                 clk = 1'b0;
    logic                 rst_n, enable, ofmap_valid_in, ofmap_ready, clear_overflow;
    row_t                 ofmap_in, ofmap_out;
    logic                 ofmap_valid, full, overflow;
    logic [$clog2(FD):0]  count;

    int total = 0;
    int bad   = 0;

    // Model state: buffered rows, sticky flag, and the last AW-1 enabled-cycle samples.
    row_t mq[$];
    bit   m_ovf;
    bit   vh[$];
    row_t dh[$];

    systolic_ofmap_deskew #(
        .OFMAP_WIDTH(W),
        .ARRAY_WIDTH(AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .ofmap_valid_in(ofmap_valid_in),
        .ofmap_in      (ofmap_in),
        .ofmap_out     (ofmap_out),
        .ofmap_valid   (ofmap_valid),
        .ofmap_ready   (ofmap_ready),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RowW-1:0] got, input logic [RowW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Row sampled valid at enabled cycle e takes column j from enabled cycle e+j.
    task automatic model_step();
        row_t r;
        bit   pop, push, drop;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
            vh.delete();
            dh.delete();
            for (int i = 0; i < AW - 1; i++) begin
                vh.push_back(1'b0);
                dh.push_back('0);
            end
            return;
        end
        pop  = (mq.size() > 0) && ofmap_ready;
        push = enable && vh[0];
        r    = '0;
        if (push) begin
            for (int j = 0; j < AW - 1; j++) r[j] = dh[j][j];
            r[AW-1] = ofmap_in[AW-1];
        end
        drop = push && (mq.size() >= FD) && !pop;
        if (pop) void'(mq.pop_front());
        if (push && !drop) mq.push_back(r);
        if (drop) m_ovf = 1'b1;
        else if (clear_overflow) m_ovf = 1'b0;
        if (enable) begin
            void'(vh.pop_front());
            vh.push_back(ofmap_valid_in);
            void'(dh.pop_front());
            dh.push_back(ofmap_in);
        end
    endtask

    task automatic compare();
        row_t exp_out;
        exp_out = (mq.size() > 0) ? mq[0] : '0;
        check("valid",    RowW'(ofmap_valid), RowW'(mq.size() > 0));
        check("count",    RowW'(count),       RowW'(mq.size()));
        check("full",     RowW'(full),        RowW'(mq.size() == FD));
        check("overflow", RowW'(overflow),    RowW'(m_ovf));
        check("out",      ofmap_out,          exp_out);
    endtask

    task automatic cycle(input bit rn, input bit en, input bit vin, input bit rdy,
                         input bit clr, input row_t din);
        rst_n          = rn;
        enable         = en;
        ofmap_valid_in = vin;
        ofmap_ready    = rdy;
        clear_overflow = clr;
        ofmap_in       = din;
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    function automatic row_t rand_row();
        row_t r;
        for (int j = 0; j < AW; j++) r[j] = $urandom;
        return r;
    endfunction

    // Column c carries base+c; every other column carries junk.
    function automatic row_t diag_row(input int c, input int base);
        row_t r;
        r = rand_row();
        r[c] = W'(base + c);
        return r;
    endfunction

    initial begin
        row_t r;
        // Reset state.
        cycle(0, 1, 0, 0, 0, rand_row());
        cycle(0, 1, 0, 0, 0, rand_row());
        check("rst_valid", RowW'(ofmap_valid), '0);
        check("rst_out",   ofmap_out,          '0);

        // Single row: column j = 10+j at cycle j, visible at cycle 4.
        for (int c = 0; c < AW; c++) cycle(1, 1, c == 0, 0, 0, diag_row(c, 10));
        check("single_valid", RowW'(ofmap_valid), RowW'(1));
        check("single_out",   ofmap_out, {32'd13, 32'd12, 32'd11, 32'd10});
        check("single_count", RowW'(count), RowW'(1));
        cycle(1, 1, 0, 1, 0, rand_row());
        check("single_drain", RowW'(count), '0);

        // Streaming 8 rows with ready high.
        for (int c = 0; c < 8 + AW + 2; c++) begin
            r = rand_row();
            for (int j = 0; j < AW; j++)
                if (c - j >= 0 && c - j < 8) r[j] = W'(100 * (c - j) + j);
            cycle(1, 1, c < 8, 1, 0, r);
        end
        check("stream_ovf", RowW'(overflow), '0);

        // Backpressure: 5 rows into a 4-deep FIFO.
        for (int c = 0; c < 5 + AW; c++) cycle(1, 1, c < 5, 0, 0, rand_row());
        check("bp_full",  RowW'(full),     RowW'(1));
        check("bp_count", RowW'(count),    RowW'(FD));
        check("bp_ovf",   RowW'(overflow), RowW'(1));
        for (int c = 0; c < FD; c++) cycle(1, 1, 0, 1, 0, rand_row());
        check("bp_drained", RowW'(full), '0);
        cycle(1, 1, 0, 0, 1, rand_row());
        check("bp_clear", RowW'(overflow), '0);

        // Enable stall of 3 cycles after column 1: valid rises at cycle 7.
        cycle(1, 1, 1, 0, 0, diag_row(0, 50));
        cycle(1, 1, 0, 0, 0, diag_row(1, 50));
        for (int c = 0; c < 3; c++) cycle(1, 0, 1, 0, 0, rand_row());
        cycle(1, 1, 0, 0, 0, diag_row(2, 50));
        check("stall_early", RowW'(ofmap_valid), '0);
        cycle(1, 1, 0, 0, 0, diag_row(3, 50));
        check("stall_valid", RowW'(ofmap_valid), RowW'(1));
        check("stall_out",   ofmap_out, {32'd53, 32'd52, 32'd51, 32'd50});

        // Reset mid-row with rows buffered.
        cycle(1, 1, 1, 0, 0, rand_row());
        cycle(1, 1, 0, 0, 0, rand_row());
        cycle(0, 1, 0, 0, 0, rand_row());
        check("midrst_count", RowW'(count), '0);
        for (int c = 0; c < AW + 2; c++) cycle(1, 1, 0, 0, 0, rand_row());
        check("midrst_quiet", RowW'(ofmap_valid), '0);

        // Randomized traffic with stalls, backpressure, clears and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) != 0,
                  (c / 200) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0,
                  rand_row());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
